isqrt_fsm: RTL

Iterative integer square-root responder for the isqrt request/response interface used by the formula FSMs. It answers `x_vld`/`x` requests with `y_vld`/`y = floor(sqrt(x))`, using one shared digit-by-digit datapath that retires 2 radicand bits per cycle. It sits behind the formula distributors and replaces the pipelined isqrt where area matters more than throughput. It accepts a new request in the same cycle it presents a result, so a client can chain requests combinationally off `y_vld`.

---
 rtl/isqrt_fsm_if.sv | 13 +
 rtl/isqrt_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/isqrt_fsm_if.sv
// isqrt request/response interface: a client issues x_vld/x, the responder
// returns y_vld/y plus busy and a sticky err flag.
interface isqrt_fsm_if;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        err;

    modport master (output x_vld, x, input  y_vld, y, busy, err);
    modport slave  (input  x_vld, x, output y_vld, y, busy, err);
endinterface

// File: rtl/isqrt_fsm.sv
// isqrt_fsm: iterative floor(sqrt(x)) responder. One digit-by-digit step per
// cycle (2 radicand bits), 16 steps per result, 17-cycle request-to-result.
// A new request is accepted in the same cycle a result is presented.
// Optional feature: define ISQRT_FSM_PENDING_BUF_EN to add a one-entry slot
// that holds a request arriving during CALC instead of dropping it.
module isqrt_fsm (
    input  logic         clk,
    input  logic         rst_n,
    isqrt_fsm_if.slave   s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [31:0] rad;
    logic [17:0] rem;
    logic [15:0] root;
    logic [3:0]  cnt;

    logic        load;
    logic [31:0] load_x;
    logic        drop;

    logic [19:0] t;
    logic [19:0] trial;
    logic        ge;
    logic [17:0] rem_nxt;
    logic [15:0] root_nxt;

`ifdef ISQRT_FSM_PENDING_BUF_EN
    logic        pend_vld;
    logic [31:0] pend_x;
    logic        pend_set;
`endif

    // One digit-by-digit step: bring down two radicand bits, try (root<<2)|1.
    always_comb begin
        t        = {rem, rad[31:30]};
        trial    = {2'b00, root, 2'b01};
        ge       = (t >= trial);
        // rem stays below 2^18 for any 32-bit radicand, so the cast loses nothing.
        rem_nxt  = 18'(ge ? (t - trial) : t);
        root_nxt = {root[14:0], ge};
    end

    // Next-state, request acceptance/drop, and status outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves
        // it unassigned and no latch is inferred.
        state_nxt = state;
        load      = 1'b0;
        load_x    = s.x;
        drop      = 1'b0;
`ifdef ISQRT_FSM_PENDING_BUF_EN
        pend_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (s.x_vld) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == 4'd15) state_nxt = DONE;
`ifdef ISQRT_FSM_PENDING_BUF_EN
                if (s.x_vld) begin
                    if (pend_vld) drop     = 1'b1;
                    else          pend_set = 1'b1;
                end
`else
                if (s.x_vld) drop = 1'b1;
`endif
            end
            DONE: begin
                state_nxt = IDLE;
                if (s.x_vld) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
`ifdef ISQRT_FSM_PENDING_BUF_EN
                // The older, buffered request goes first; a fresh one refills the slot.
                if (pend_vld) begin
                    load      = 1'b1;
                    load_x    = pend_x;
                    state_nxt = CALC;
                    pend_set  = s.x_vld;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        s.y_vld = (state == DONE);
`ifdef ISQRT_FSM_PENDING_BUF_EN
        s.busy  = (state == CALC) || pend_vld;
`else
        s.busy  = (state == CALC);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: load a request or advance one iteration while in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is reset too, so an aborted computation leaves no
        // stale partial result behind.
        if (!rst_n) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (load) begin
            rad  <= load_x;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (state == CALC) begin
            rad  <= {rad[29:0], 2'b00};
            rem  <= rem_nxt;
            root <= root_nxt;
            cnt  <= cnt + 4'd1;
        end
    end

    // Result register: updated only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           s.y <= '0;
        else if (state == CALC && cnt == 4'd15) s.y <= root_nxt;
    end

    // Sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    s.err <= 1'b0;
        else if (drop) s.err <= 1'b1;
    end

`ifdef ISQRT_FSM_PENDING_BUF_EN
    // Pending slot: filled in CALC or refilled in DONE, otherwise drained in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_x   <= '0;
        end else if (pend_set) begin
            pend_vld <= 1'b1;
            pend_x   <= s.x;
        end else if (state == DONE) begin
            pend_vld <= 1'b0;
        end
    end
`endif

endmodule
